mouse_pos_tracker: RTL

- Produces the cursor interface the menu and game-control path consume: `xpos`, `ypos`, and the button levels.
- Sits between the PS/2 byte receiver and the video pipeline.
- Assembles standard 3-byte PS/2 mouse packets from a byte-valid stream and accumulates signed X/Y deltas.
- Positions are clamped to the visible screen area; button states are registered.

---
 rtl/mouse_pos_tracker_if.sv | 34 +++
 rtl/mouse_pos_tracker.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/mouse_pos_tracker_if.sv
// rtl/mouse_pos_tracker_if.sv - byte stream in, cursor position/buttons out
//
// Bundles the PS/2 byte-receiver stream and the cursor outputs of
// mouse_pos_tracker.
//   rx_data     [7:0]  byte from the PS/2 receiver
//   rx_valid           one-cycle strobe, rx_data valid
//   rx_error           one-cycle strobe, receiver parity/framing error
//   xpos        [11:0] cursor X, 0..X_MAX
//   ypos        [11:0] cursor Y, 0..Y_MAX, screen-down positive
//   mouse_left         left button level
//   mouse_right        right button level
//   pos_valid          one-cycle pulse, outputs just updated
// Modports: master = byte source / cursor consumer, slave = the tracker.

interface mouse_pos_tracker_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_error;
    logic [11:0] xpos;
    logic [11:0] ypos;
    logic        mouse_left;
    logic        mouse_right;
    logic        pos_valid;

    modport master (
        output rx_data, rx_valid, rx_error,
        input  xpos, ypos, mouse_left, mouse_right, pos_valid
    );

    modport slave (
        input  rx_data, rx_valid, rx_error,
        output xpos, ypos, mouse_left, mouse_right, pos_valid
    );
endinterface

// File: rtl/mouse_pos_tracker.sv
// rtl/mouse_pos_tracker.sv - PS/2 3-byte packet assembler and clamped cursor accumulator
//
// Assembles 3-byte PS/2 mouse packets from the receiver byte stream,
// accumulates the signed X/Y deltas into a cursor position clamped to the
// visible screen and registers the button levels.
// Ports:
//   pclk  system clock, rising edge
//   rst   asynchronous active-low reset
//   bus   mouse_pos_tracker_if.slave (rx_data/rx_valid/rx_error in,
//         xpos/ypos/mouse_left/mouse_right/pos_valid out)
// Optional feature macro: MOUSE_ACCEL_EN - doubles deltas whose magnitude
// is at least ACCEL_THRESH before they are added and clamped.

module mouse_pos_tracker #(
    parameter int X_MAX        = 799,
    parameter int Y_MAX        = 599,
    parameter int X_INIT       = 400,
    parameter int Y_INIT       = 300,
    parameter int TIMEOUT      = 65000,
    parameter int ACCEL_THRESH = 16
) (
    input  logic               pclk,
    input  logic               rst,
    mouse_pos_tracker_if.slave bus
);

`ifdef MOUSE_ACCEL_EN
    localparam bit ACCEL_ON = 1'b1;
`else
    localparam bit ACCEL_ON = 1'b0;
`endif

    localparam logic signed [12:0] X_MAX13   = 13'(X_MAX);
    localparam logic signed [12:0] Y_MAX13   = 13'(Y_MAX);
    localparam logic signed [12:0] ACCEL_T13 = 13'(ACCEL_THRESH);
    localparam logic [15:0]        TMO_LIM   = 16'(TIMEOUT);

    typedef enum logic [1:0] {
        WAIT_B0,
        WAIT_B1,
        WAIT_B2,
        UPDATE
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  b0_q, b0_d;
    logic [7:0]  b1_q, b1_d;
    logic [7:0]  b2_q, b2_d;
    logic [15:0] tmo_cnt_q, tmo_cnt_d;
    logic [11:0] xpos_q, xpos_d;
    logic [11:0] ypos_q, ypos_d;
    logic        left_q, left_d;
    logic        right_q, right_d;
    logic        pos_valid_q, pos_valid_d;

    logic signed [12:0] dx, dy, nx, ny;

    function automatic logic signed [12:0] accel(input logic signed [12:0] d);
        if (ACCEL_ON && ((d >= ACCEL_T13) || (d <= -ACCEL_T13)))
            return d + d;
        return d;
    endfunction

    function automatic logic [11:0] clamp(input logic signed [12:0] v,
                                          input logic signed [12:0] maxv);
        if (v < 13'sd0)
            return 12'd0;
        if (v > maxv)
            return maxv[11:0];
        return v[11:0];
    endfunction

    // New position from the latched packet; only committed in UPDATE.
    always_comb begin
        dx = b0_q[6] ? 13'sd0 : {{4{b0_q[4]}}, b0_q[4], b1_q};
        dy = b0_q[7] ? 13'sd0 : {{4{b0_q[5]}}, b0_q[5], b2_q};
        dx = accel(dx);
        dy = accel(dy);
        nx = $signed({1'b0, xpos_q}) + dx;
        // PS/2 reports Y up-positive; the screen counts down.
        ny = $signed({1'b0, ypos_q}) - dy;
    end

    always_comb begin
        state_d     = state_q;
        b0_d        = b0_q;
        b1_d        = b1_q;
        b2_d        = b2_q;
        tmo_cnt_d   = 16'd0;
        xpos_d      = xpos_q;
        ypos_d      = ypos_q;
        left_d      = left_q;
        right_d     = right_q;
        pos_valid_d = 1'b0;

        case (state_q)
            WAIT_B0: begin
                // Bytes without the always-one sync bit are dropped to resync.
                if (!bus.rx_error && bus.rx_valid && bus.rx_data[3]) begin
                    b0_d    = bus.rx_data;
                    state_d = WAIT_B1;
                end
            end
            WAIT_B1: begin
                if (bus.rx_error) begin
                    state_d = WAIT_B0;
                end else if (bus.rx_valid) begin
                    b1_d    = bus.rx_data;
                    state_d = WAIT_B2;
                end else if (tmo_cnt_q >= TMO_LIM) begin
                    state_d = WAIT_B0;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 16'd1;
                end
            end
            WAIT_B2: begin
                if (bus.rx_error) begin
                    state_d = WAIT_B0;
                end else if (bus.rx_valid) begin
                    b2_d    = bus.rx_data;
                    state_d = UPDATE;
                end else if (tmo_cnt_q >= TMO_LIM) begin
                    state_d = WAIT_B0;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 16'd1;
                end
            end
            UPDATE: begin
                // The update always completes; a byte arriving now is
                // treated as a first-byte candidate so nothing is lost.
                xpos_d      = clamp(nx, X_MAX13);
                ypos_d      = clamp(ny, Y_MAX13);
                left_d      = b0_q[0];
                right_d     = b0_q[1];
                pos_valid_d = 1'b1;
                state_d     = WAIT_B0;
                if (!bus.rx_error && bus.rx_valid && bus.rx_data[3]) begin
                    b0_d    = bus.rx_data;
                    state_d = WAIT_B1;
                end
            end
            default: state_d = WAIT_B0;
        endcase
    end

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            state_q     <= WAIT_B0;
            b0_q        <= 8'd0;
            b1_q        <= 8'd0;
            b2_q        <= 8'd0;
            tmo_cnt_q   <= 16'd0;
            xpos_q      <= 12'(X_INIT);
            ypos_q      <= 12'(Y_INIT);
            left_q      <= 1'b0;
            right_q     <= 1'b0;
            pos_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            b0_q        <= b0_d;
            b1_q        <= b1_d;
            b2_q        <= b2_d;
            tmo_cnt_q   <= tmo_cnt_d;
            xpos_q      <= xpos_d;
            ypos_q      <= ypos_d;
            left_q      <= left_d;
            right_q     <= right_d;
            pos_valid_q <= pos_valid_d;
        end
    end

    assign bus.xpos        = xpos_q;
    assign bus.ypos        = ypos_q;
    assign bus.mouse_left  = left_q;
    assign bus.mouse_right = right_q;
    assign bus.pos_valid   = pos_valid_q;

endmodule
